// File: rtl/inst_imm_enc.sv
// inst_imm_enc: streaming RISC-V immediate encoder with an output FIFO.
// Packs imm_i into the immediate fields of base_i according to ImmSel_i,
// flags immediates that the selected format cannot represent, and queues
// {err, inst} words behind a valid/ready handshake.
// Optional feature macro: IMM_ENC_ERR_CNT_EN (saturating error counter).

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef J_TYPE
`define J_TYPE 3'd3
`endif
`ifndef U_TYPE
`define U_TYPE 3'd4
`endif

module inst_imm_enc #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      base_i,
  input  logic [31:0]      imm_i,
  input  logic [2:0]       ImmSel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      inst_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_CW = $clog2(DEPTH + 1);
  localparam logic [CNT_CW-1:0] FULL_CNT = CNT_CW'(DEPTH);

  logic [31:0]       enc_inst;
  logic              enc_err;
  logic [32:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_CW-1:0] cnt_q, cnt_d;
  logic              full, empty, push, pop;

  // Field packing and range check for the selected immediate format.
  always_comb begin
    enc_inst = base_i;
    enc_err  = 1'b0;
    case (ImmSel_i)
      `I_TYPE: begin
        enc_inst[31:20] = imm_i[11:0];
        enc_err = (imm_i != {{20{imm_i[11]}}, imm_i[11:0]});
      end
      `S_TYPE: begin
        enc_inst[31:25] = imm_i[11:5];
        enc_inst[11:7]  = imm_i[4:0];
        enc_err = (imm_i != {{20{imm_i[11]}}, imm_i[11:0]});
      end
      `B_TYPE: begin
        enc_inst[31]    = imm_i[12];
        enc_inst[30:25] = imm_i[10:5];
        enc_inst[11:8]  = imm_i[4:1];
        enc_inst[7]     = imm_i[11];
        enc_err = (imm_i != {{19{imm_i[12]}}, imm_i[12:0]}) || imm_i[0];
      end
      `J_TYPE: begin
        enc_inst[31]    = imm_i[20];
        enc_inst[30:21] = imm_i[10:1];
        enc_inst[20]    = imm_i[11];
        enc_inst[19:12] = imm_i[19:12];
        enc_err = (imm_i != {{11{imm_i[20]}}, imm_i[20:0]}) || imm_i[0];
      end
      `U_TYPE: begin
        enc_inst[31:12] = imm_i[31:12];
        enc_err = (imm_i[11:0] != 12'd0);
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign ready_o = !full;
  assign valid_o = !empty;
  assign push    = valid_i && !full && !flush_i;
  assign pop     = !empty && ready_i;

  // Occupancy next state; flush wins over any push/pop in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)
      cnt_d = '0;
    else if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !push)
      cnt_d = cnt_q - 1'b1;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= {enc_err, enc_inst};
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Head entry is shown only while valid so an empty FIFO reads as zero.
  assign inst_o = valid_o ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign err_o  = valid_o ? mem_q[rd_ptr_q][32]   : 1'b0;

`ifdef IMM_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Count accepted erroneous words, saturating; flush does not clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_cnt_q <= '0;
    else if (push && enc_err && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_imm_enc.sv
// Directed testbench for inst_imm_enc (DEPTH=2).

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef J_TYPE
`define J_TYPE 3'd3
`endif
`ifndef U_TYPE
`define U_TYPE 3'd4
`endif

module tb_inst_imm_enc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] base_i = '0;
  logic [31:0] imm_i = '0;
  logic [2:0]  ImmSel_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] inst_o;
  logic        err_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = '0;

  inst_imm_enc #(.DEPTH(2), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .base_i(base_i),
    .imm_i(imm_i), .ImmSel_i(ImmSel_i), .valid_o(valid_o),
    .ready_i(ready_i), .inst_o(inst_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic note_err(input logic e);
`ifdef IMM_ENC_ERR_CNT_EN
    if (e && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  // Push one word with the consumer stalled, check the head, then pop it.
  task automatic one(input string tag, input logic [31:0] b, input logic [31:0] im,
                     input logic [2:0] sel, input logic [31:0] ei, input logic ee);
    @(negedge clk_i);
    base_i = b; imm_i = im; ImmSel_i = sel; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    note_err(ee);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, "_inst"}, inst_o, ei);
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, ee});
    check({tag, "_cnt"}, {16'd0, err_cnt_o}, {16'd0, exp_cnt});
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_drained"}, {31'd0, valid_o}, 32'd0);
  endtask

  task automatic put(input logic [31:0] im);
    base_i = 32'h0000_0013; imm_i = im; ImmSel_i = `I_TYPE; valid_i = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    @(negedge clk_i); rst_i = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_inst", inst_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cnt", {16'd0, err_cnt_o}, 32'd0);

    // Encoding vectors
    one("i_neg1",  32'h0000_0013, 32'hFFFF_FFFF, `I_TYPE, 32'hFFF0_0013, 1'b0);
    one("i_ovf",   32'h0000_0013, 32'h0000_0800, `I_TYPE, 32'h8000_0013, 1'b1);
    one("s_neg",   32'h0000_0023, 32'hFFFF_FFE5, `S_TYPE, 32'hFE00_02A3, 1'b0);
    one("b_800",   32'h0000_0063, 32'h0000_0800, `B_TYPE, 32'h0000_00E3, 1'b0);
    one("b_odd",   32'h0000_0063, 32'h0000_0003, `B_TYPE, 32'h0000_0163, 1'b1);
    one("j_neg2",  32'h0000_006F, 32'hFFFF_FFFE, `J_TYPE, 32'hFFFF_F06F, 1'b0);
    one("j_ovf",   32'h0000_006F, 32'h0010_0000, `J_TYPE, 32'h8000_006F, 1'b1);
    one("u_ok",    32'h0000_0037, 32'h1234_5000, `U_TYPE, 32'h1234_5037, 1'b0);
    one("u_low",   32'h0000_0037, 32'h1234_5001, `U_TYPE, 32'h1234_5037, 1'b1);
    one("bad_sel", 32'hDEAD_BEEF, 32'h0000_0000, 3'd7,    32'hDEAD_BEEF, 1'b1);

    // Backpressure: A, B fill the FIFO, C is held
    @(negedge clk_i); ready_i = 1'b0; put(32'd1);
    @(negedge clk_i); put(32'd2);
    @(posedge clk_i); #1;
    check("bp_full_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i); put(32'd3);
    @(posedge clk_i); #1;
    check("bp_held_ready", {31'd0, ready_o}, 32'd0);
    check("bp_head_a", inst_o, 32'h0010_0013);
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_head_b", inst_o, 32'h0020_0013);
    check("bp_ready_rise", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("bp_head_c", inst_o, 32'h0030_0013);
    check("bp_valid_c", {31'd0, valid_o}, 32'd1);
    @(posedge clk_i); #1;
    check("bp_empty", {31'd0, valid_o}, 32'd0);

    // Flush with two entries; same-cycle push is dropped
    @(negedge clk_i); ready_i = 1'b0; put(32'd4);
    @(negedge clk_i); put(32'd5);
    @(negedge clk_i); flush_i = 1'b1; put(32'h800);
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("fl_valid", {31'd0, valid_o}, 32'd0);
    check("fl_ready", {31'd0, ready_o}, 32'd1);
    check("fl_cnt", {16'd0, err_cnt_o}, {16'd0, exp_cnt});
    @(posedge clk_i); #1;
    check("fl_stay_empty", {31'd0, valid_o}, 32'd0);

    // Reset mid-drain
    @(negedge clk_i); put(32'd6);
    @(negedge clk_i); put(32'd7);
    @(negedge clk_i); valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("rd_head_7", inst_o, 32'h0070_0013);
    rst_i = 1'b1; #1;
    check("rd_async_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b0; ready_i = 1'b0; exp_cnt = '0;
    #1;
    check("rd_valid", {31'd0, valid_o}, 32'd0);
    check("rd_ready", {31'd0, ready_o}, 32'd1);
    check("rd_cnt", {16'd0, err_cnt_o}, {16'd0, exp_cnt});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_imm_enc.md
Name: inst_imm_enc

Overview:
- Streaming immediate encoder for the CPU: packs a 32-bit immediate value into the immediate bit positions of a RISC-V instruction word, selected by immediate type.
- Exact inverse of the core's immediate generator. For every error-free output word, decoding inst_o with the same ImmSel returns imm_i.
- Sits between the secure-boot patch engine and instruction memory write port.
- Buffers results in a small output FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, output FIFO entries (power of two, 2..8)
CNT_W, 16, width of optional error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  synchronous FIFO clear
valid_i  in  1  input request valid
ready_o  out  1  input ready (FIFO not full)
base_i  in  32  template instruction (opcode/rd/rs1/rs2/funct fields)
imm_i  in  32  immediate value to encode
ImmSel_i  in  3  immediate type: `I_TYPE/`S_TYPE/`B_TYPE/`J_TYPE/`U_TYPE from define.sv
valid_o  out  1  output word valid
ready_i  in  1  consumer ready
inst_o  out  32  encoded instruction
err_o  out  1  immediate not representable for selected type
err_cnt_o  out  CNT_W  error count (see Optional Feature)

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: FIFO empty, valid_o=0, inst_o=0, err_o=0, err_cnt_o=0, ready_o=1 after reset deasserts.
- Push occurs on valid_i && ready_o. Pop occurs on valid_o && ready_i.
- ready_o = !full, registered state only; no combinational dependence on ready_i.
- Latency: a word pushed into an empty FIFO appears on valid_o the next cycle.
- inst_o/err_o show the head entry. They hold stable while valid_o && !ready_i.
- Encoding: bits not listed below are copied from base_i.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
  - Any other ImmSel: inst=base_i unchanged, err=1.
- Range check (err=1 if violated):
  - I/S: imm_i sign-extended from bit 11 must equal imm_i.
  - B: sign-extension from bit 12 must equal imm_i, and imm[0]=0.
  - J: sign-extension from bit 20 must equal imm_i, and imm[0]=0.
  - U: imm[11:0]=0.
- When err=1 the word is still encoded with truncated bits and still pushed; err travels with the entry.
- FIFO boundary cases:
  - Full: ready_o=0. A pop that cycle frees a slot, and ready_o rises the following cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- flush_i empties the FIFO next cycle and drops any push in the same cycle. It does not clear err_cnt_o.
- rst_i mid-stream discards all entries immediately.

Optional Feature:
- Macro: IMM_ENC_ERR_CNT_EN.
- Defined: err_cnt_o increments on each accepted push with err=1 and saturates at all-ones. It is cleared only by rst_i.
- Undefined: err_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF, valid_o one cycle after push, ready_i=1 -> inst_o=0xFFF00013, err_o=0.
- B: base 0x00000063, imm 0x00000800 -> inst_o=0x000000E3, err_o=0; same with imm 0x00000003 -> err_o=1.
- J: base 0x0000006F, imm 0xFFFFFFFE -> inst_o=0xFFFFF06F, err_o=0; imm 0x00100000 -> err_o=1.
- U: base 0x00000037, imm 0x12345000 -> 0x12345037 err 0; imm 0x12345001 -> 0x12345037 err 1; with IMM_ENC_ERR_CNT_EN, err_cnt_o=1.
- Backpressure, DEPTH=2, ready_i=0, three back-to-back pushes -> ready_o=0 after second; third held. Raise ready_i -> words drain in order, third accepted.
- Reset/flush: assert flush_i with 2 entries -> valid_o=0 next cycle. Assert rst_i mid-drain -> valid_o=0, ready_o=1 immediately after deassert.
